// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Far-end responder for the core's load/store interface. Accepts one request
//   at a time over valid/ready, waits a configurable latency, then pulses a
//   one-cycle response. Serves byte/halfword/word loads and stores against an
//   internal word-organised RAM built from four byte-lane arrays.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   req_valid   request present
//   req_ready   responder idle and able to accept
//   memread     load enable
//   memwrite    store enable (wins over memread)
//   funct3      000 b, 001 h, 010 w, 100 bu, 101 hu
//   addr        byte address (wraps modulo RAM size)
//   write_data  store data, low-aligned
//   resp_valid  one-cycle response pulse
//   read_data   extended load result, 0 for stores/errors/no-ops
//   resp_err    misaligned access or illegal funct3 (valid with resp_valid)
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic        resp_valid,
   output logic [31:0] read_data,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_reg;
   logic [CW-1:0]   count_reg;

   // Request captured at the accept edge
   logic            wr_reg;
   logic            rd_reg;
   logic [2:0]      f3_reg;
   logic [AW+1:0]   addr_reg;
   logic [31:0]     wdata_reg;

   // Load formatting info captured at the RAM access edge, so read_data
   // holds steady until the next response even if a new request is latched
   logic            rsp_load_reg;
   logic [2:0]      rsp_f3_reg;
   logic [1:0]      rsp_off_reg;

   // Operation being executed. With a single-cycle latency the RAM access
   // happens on the accept edge itself, so the live inputs are used.
   logic            op_wr;
   logic            op_rd;
   logic [2:0]      op_f3;
   logic [AW+1:0]   op_addr;
   logic [31:0]     op_wdata;

   assign op_wr    = (LATENCY == 1) ? memwrite         : wr_reg;
   assign op_rd    = (LATENCY == 1) ? memread          : rd_reg;
   assign op_f3    = (LATENCY == 1) ? funct3           : f3_reg;
   assign op_addr  = (LATENCY == 1) ? addr[AW+1:0]     : addr_reg;
   assign op_wdata = (LATENCY == 1) ? write_data       : wdata_reg;

   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[31:AW+2];

   assign req_ready = (state_reg == IDLE);

   // The edge that performs the RAM access and enters RESP
   logic commit;
   assign commit = (LATENCY == 1) ? (state_reg == IDLE && req_valid)
                                  : (state_reg == WAIT && count_reg == '0);

   // Access decode
   logic       is_store;
   logic       is_load;
   logic       f3_legal;
   logic       misaligned;
   logic       acc_err;
   logic [3:0] byte_en;
   logic [31:0] lane_wdata;
   logic       store_en;

   always_comb begin
      is_store   = op_wr;
      is_load    = !op_wr && op_rd;
      if (is_store)
         f3_legal = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010);
      else
         f3_legal = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010) ||
                    (op_f3 == 3'b100) || (op_f3 == 3'b101);
      misaligned = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                   ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
      acc_err    = (is_store || is_load) && (!f3_legal || misaligned);
      case (op_f3[1:0])
         2'b00:   byte_en = 4'b0001 << op_addr[1:0];
         2'b01:   byte_en = op_addr[1] ? 4'b1100 : 4'b0011;
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
      // Replicate narrow data across lanes; byte_en picks the real target
      case (op_f3[1:0])
         2'b00:   lane_wdata = {4{op_wdata[7:0]}};
         2'b01:   lane_wdata = {2{op_wdata[15:0]}};
         default: lane_wdata = op_wdata;
      endcase
      store_en   = commit && is_store && !acc_err;
   end

   // Control FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         wr_reg       <= 1'b0;
         rd_reg       <= 1'b0;
         f3_reg       <= 3'b000;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rsp_load_reg <= 1'b0;
         rsp_f3_reg   <= 3'b000;
         rsp_off_reg  <= 2'b00;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  wr_reg    <= memwrite;
                  rd_reg    <= memread;
                  f3_reg    <= funct3;
                  addr_reg  <= addr[AW+1:0];
                  wdata_reg <= write_data;
                  count_reg <= (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (count_reg != '0)
                  count_reg <= count_reg - 1'b1;
            end
            RESP: begin
               resp_valid <= 1'b0;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
         // Access edge overrides the case above (covers single-cycle latency)
         if (commit) begin
            state_reg    <= RESP;
            resp_valid   <= 1'b1;
            resp_err     <= acc_err;
            rsp_load_reg <= is_load && !acc_err;
            rsp_f3_reg   <= op_f3;
            rsp_off_reg  <= op_addr[1:0];
         end
      end
   end

   // RAM: one byte-wide array per lane, registered read on the access edge
   logic [31:0] raw_word;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] q_reg;
         always_ff @(posedge clk) begin
            if (store_en && byte_en[gi])
               mem[op_addr[AW+1:2]] <= lane_wdata[gi*8 +: 8];
            if (commit)
               q_reg <= mem[op_addr[AW+1:2]];
         end
         assign raw_word[gi*8 +: 8] = q_reg;
      end
   endgenerate

   // Load extraction and extension
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      case (rsp_off_reg)
         2'b00:   sel_byte = raw_word[7:0];
         2'b01:   sel_byte = raw_word[15:8];
         2'b10:   sel_byte = raw_word[23:16];
         default: sel_byte = raw_word[31:24];
      endcase
      sel_half = rsp_off_reg[1] ? raw_word[31:16] : raw_word[15:0];
      read_data = 32'h0;
      if (rsp_load_reg) begin
         case (rsp_f3_reg)
            3'b000:  read_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  read_data = {24'h0, sel_byte};
            3'b001:  read_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  read_data = {16'h0, sel_half};
            default: read_data = raw_word;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        memread;
   logic        memwrite;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        resp_valid;
   logic [31:0] read_data;
   logic        resp_err;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .memread    (memread),
      .memwrite   (memwrite),
      .funct3     (funct3),
      .addr       (addr),
      .write_data (write_data),
      .resp_valid (resp_valid),
      .read_data  (read_data),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Byte-addressed memory; each access is applied at its response time so an
   // access aborted by reset leaves no trace.
   logic [7:0]  mbytes [4*DEPTH];
   int          ph = 0;           // cycles since accept, 0 = idle
   int          model_accepts = 0;
   logic        m_wr, m_rd;
   logic [2:0]  m_f3;
   logic [31:0] m_addr, m_wd;

   int          resp_count = 0;
   logic [31:0] last_rd;
   logic        last_err;

   task automatic model_exec(output logic [31:0] e_rd, output logic e_err);
      int unsigned ba;
      int nb;
      logic [31:0] v;
      ba = m_addr & (4*DEPTH - 1);
      case (m_f3)
         3'd0, 3'd4: nb = 1;
         3'd1, 3'd5: nb = 2;
         3'd2:       nb = 4;
         default:    nb = 0;
      endcase
      if (m_wr && m_f3[2]) nb = 0;
      e_rd  = 32'h0;
      e_err = 1'b0;
      if (!m_wr && !m_rd) begin
         e_err = 1'b0;
      end else if (nb == 0 || (ba % nb) != 0) begin
         e_err = 1'b1;
      end else if (m_wr) begin
         for (int i = 0; i < nb; i++) mbytes[ba + i] = m_wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(mbytes[ba + i]) << (8*i));
         if (!m_f3[2] && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
         if (!m_f3[2] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
         e_rd = v;
      end
   endtask

   // Per-cycle compare, mid-cycle
   always @(negedge clk) begin
      logic [31:0] e_rd;
      logic        e_err;
      if (reset) begin
         chk("reset_ready", {31'h0, req_ready}, 32'h1);
         chk("reset_valid", {31'h0, resp_valid}, 32'h0);
         chk("reset_rdata", read_data, 32'h0);
         chk("reset_err",   {31'h0, resp_err}, 32'h0);
         ph = 0;
      end else begin
         chk("req_ready",  {31'h0, req_ready},  {31'h0, (ph == 0)});
         chk("resp_valid", {31'h0, resp_valid}, {31'h0, (ph == LAT)});
         if (ph == LAT) begin
            model_exec(e_rd, e_err);
            chk("read_data", read_data, e_rd);
            chk("resp_err",  {31'h0, resp_err}, {31'h0, e_err});
         end
         if (resp_valid) begin
            last_rd  = read_data;
            last_err = resp_err;
            resp_count++;
         end
         if (ph == 0) begin
            if (req_valid) begin
               m_wr = memwrite; m_rd = memread; m_f3 = funct3;
               m_addr = addr; m_wd = write_data;
               model_accepts++;
               ph = 1;
            end
         end else if (ph == LAT) begin
            ph = 0;
         end else begin
            ph++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         n_fail++;
         $display("FAIL %s: req_ready still 0 after 20 cycles, expected 1", name);
      end
   endtask

   task automatic drive_req(input logic wr, input logic rd, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; memwrite = wr; memread = rd; funct3 = f3;
      addr = a; write_data = wd;
      @(posedge clk); #1;
      // Scramble inputs: the responder must use the latched request
      req_valid = 1'b0; memwrite = ~wr; memread = 1'b1; funct3 = 3'b111;
      addr = 32'hFFFF_FFFF; write_data = 32'h5A5A_5A5A;
   endtask

   task automatic acc(input string name, input logic wr, input logic rd, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
      int start, n;
      wait_ready(name);
      start = resp_count;
      drive_req(wr, rd, f3, a, wd);
      n = 0;
      while (resp_count == start && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (resp_count == start) begin
         n_fail++;
         $display("FAIL %s: no resp_valid within 20 cycles, expected one", name);
      end else begin
         chk({name, "_rdata"}, last_rd, exp_rd);
         chk({name, "_err"}, {31'h0, last_err}, {31'h0, exp_err});
      end
      $display("txn %-10s wr=%0d rd=%0d f3=%03b addr=0x%08h wd=0x%08h -> rdata=0x%08h err=%0d",
               name, wr, rd, f3, a, wd, last_rd, last_err);
   endtask

   initial begin
      int base_acc, base_rsp;
      for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = 8'h00;
      reset = 1'b1; req_valid = 1'b0; memread = 1'b1; memwrite = 1'b0;
      funct3 = 3'b010; addr = 32'h0; write_data = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // word store / load
      acc("sw_10",  1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
      acc("lw_10",  0, 1, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);

      // byte access
      acc("sw_20",  1, 1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 0);
      acc("sb_21",  1, 1, 3'b000, 32'h21, 32'h0000_00AB, 32'h0, 0);
      acc("lw_20",  0, 1, 3'b010, 32'h20, 32'h0, 32'h1122_AB44, 0);
      acc("lb_21",  0, 1, 3'b000, 32'h21, 32'h0, 32'hFFFF_FFAB, 0);
      acc("lbu_21", 0, 1, 3'b100, 32'h21, 32'h0, 32'h0000_00AB, 0);

      // halfword access
      acc("sw_30",  1, 1, 3'b010, 32'h30, 32'h1234_5678, 32'h0, 0);
      acc("sh_32",  1, 1, 3'b001, 32'h32, 32'hCAFE_8001, 32'h0, 0);
      acc("lh_32",  0, 1, 3'b001, 32'h32, 32'h0, 32'hFFFF_8001, 0);
      acc("lhu_32", 0, 1, 3'b101, 32'h32, 32'h0, 32'h0000_8001, 0);
      acc("lw_30",  0, 1, 3'b010, 32'h30, 32'h0, 32'h8001_5678, 0);

      // errors and no-op
      acc("sw_40",  1, 1, 3'b010, 32'h40, 32'hA5A5_A5A5, 32'h0, 0);
      acc("lw_41",  0, 1, 3'b010, 32'h41, 32'h0, 32'h0, 1);
      acc("sh_43",  1, 1, 3'b001, 32'h43, 32'h0000_1111, 32'h0, 1);
      acc("sbu_40", 1, 0, 3'b100, 32'h40, 32'h0000_0022, 32'h0, 1);
      acc("l011_40",0, 1, 3'b011, 32'h40, 32'h0, 32'h0, 1);
      acc("nop_40", 0, 0, 3'b010, 32'h40, 32'h0, 32'h0, 0);
      acc("lw_40",  0, 1, 3'b010, 32'h40, 32'h0, 32'hA5A5_A5A5, 0);

      // address wrap
      acc("sw_1004",1, 1, 3'b010, 32'h1004, 32'h0000_0005, 32'h0, 0);
      acc("lw_4",   0, 1, 3'b010, 32'h4, 32'h0, 32'h0000_0005, 0);

      // req_valid held high: one accept per LAT+1 cycles
      base_acc = model_accepts;
      base_rsp = resp_count;
      req_valid = 1'b1; memwrite = 1'b0; memread = 1'b1; funct3 = 3'b010; addr = 32'h4;
      repeat (9) begin @(posedge clk); #1; end
      req_valid = 1'b0;
      chk("hold_accepts", 32'(model_accepts - base_acc), 32'd3);
      chk("hold_resps",   32'(resp_count - base_rsp), 32'd3);
      $display("txn hold       lw 0x4 x9 cycles -> accepts=%0d resps=%0d",
               model_accepts - base_acc, resp_count - base_rsp);
      @(posedge clk); #1;

      // reset during WAIT aborts a store
      acc("sw_50",  1, 1, 3'b010, 32'h50, 32'h0, 32'h0, 0);
      wait_ready("sw_50_rst");
      base_rsp = resp_count;
      drive_req(1'b1, 1'b1, 3'b010, 32'h50, 32'h77);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_no_resp", 32'(resp_count - base_rsp), 32'd0);
      $display("txn sw_50_rst  reset in WAIT -> resps=%0d", resp_count - base_rsp);
      acc("lw_50",  0, 1, 3'b010, 32'h50, 32'h0, 32'h0, 0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
